// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART encodings, FSM state type and baud divisor helper
package uart_pkg;

    localparam logic [1:0] BD_1200    = 2'b00;
    localparam logic [1:0] BD_2400    = 2'b01;
    localparam logic [1:0] BD_4800    = 2'b10;
    localparam logic [1:0] BD_9600    = 2'b11;

    localparam logic [1:0] PRTY_NONE  = 2'b00;
    localparam logic [1:0] PRTY_ODD   = 2'b01;
    localparam logic [1:0] PRTY_EVEN  = 2'b10;
    localparam logic [1:0] PRTY_NONE2 = 2'b11;

    localparam logic       STOP_1     = 1'b0;
    localparam logic       STOP_2     = 1'b1;

    localparam logic       DBITS_7    = 1'b0;
    localparam logic       DBITS_8    = 1'b1;

    localparam logic [3:0] BREAK_LAST = 4'd12;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
`ifdef UART_TX_BREAK_EN
        , BREAK
`endif
    } tx_state_t;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] bd;
        logic [1:0] prty;
        logic       stop;
        logic       dbits;
    } tx_shadow_t;

    // Rounded divisor: every bit lasts exactly this many clocks.
    function automatic logic [15:0] baud_div(input int clk_hz, input logic [1:0] bd_sel);
        int baud;
        case (bd_sel)
            BD_1200: baud = 1200;
            BD_2400: baud = 2400;
            BD_4800: baud = 4800;
            default: baud = 9600;
        endcase
        baud_div = 16'((clk_hz + baud / 2) / baud);
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - bit-time divider, pulses tick on the last clock of each bit
module baud_tick_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] div,
    output logic        tick
);

    logic [15:0] cnt;

    assign tick = (cnt == div - 16'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART frame transmitter; UART_TX_BREAK_EN adds brk_req and the BREAK state
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] bd_sel,
    input  logic [1:0] prty_sel,
    input  logic       stop_sel,
    input  logic       data_bit_sel,
    input  logic [7:0] data_in_Tx,
    input  logic       tx_valid,
`ifdef UART_TX_BREAK_EN
    input  logic       brk_req,
`endif
    output logic       tx_ready,
    output logic       data_out_Tx,
    output logic       busy
);

    localparam logic [15:0] DIV_1200 = baud_div(CLK_HZ, BD_1200);
    localparam logic [15:0] DIV_2400 = baud_div(CLK_HZ, BD_2400);
    localparam logic [15:0] DIV_4800 = baud_div(CLK_HZ, BD_4800);
    localparam logic [15:0] DIV_9600 = baud_div(CLK_HZ, BD_9600);

    tx_state_t  state;
    tx_shadow_t sh;
    logic [2:0] bit_idx;
    logic       stop_cnt;
    logic [15:0] cur_div;
    logic       tick;
    logic       start_frame;
    logic       start_break;
    logic [2:0] last_idx;
    logic [2:0] next_idx;
    logic [7:0] par_data;
    logic       par_en;
    logic       par_bit;
`ifdef UART_TX_BREAK_EN
    logic [3:0] brk_cnt;
`endif

    always_comb begin
        cur_div = DIV_9600;
        case (sh.bd)
            BD_1200: cur_div = DIV_1200;
            BD_2400: cur_div = DIV_2400;
            BD_4800: cur_div = DIV_4800;
            default: cur_div = DIV_9600;
        endcase
    end

`ifdef UART_TX_BREAK_EN
    assign start_break = (state == IDLE) && tx_ready && brk_req;
`else
    assign start_break = 1'b0;
`endif
    assign start_frame = (state == IDLE) && tx_ready && tx_valid && !start_break;

    assign last_idx = (sh.dbits == DBITS_8) ? 3'd7 : 3'd6;
    assign next_idx = bit_idx + 3'd1;
    // In 7-bit mode bit 7 is neither sent nor counted in the parity.
    assign par_data = (sh.dbits == DBITS_8) ? sh.data : {1'b0, sh.data[6:0]};
    assign par_en   = (sh.prty == PRTY_ODD) || (sh.prty == PRTY_EVEN);
    assign par_bit  = (sh.prty == PRTY_ODD) ? ~(^par_data) : (^par_data);

    baud_tick_gen u_tick (
        .clk  (clk),
        .rst  (rst),
        .load (start_frame || start_break),
        .div  (cur_div),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            sh          <= '0;
            bit_idx     <= '0;
            stop_cnt    <= 1'b0;
            data_out_Tx <= 1'b1;
            tx_ready    <= 1'b0;
            busy        <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_cnt     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    data_out_Tx <= 1'b1;
                    tx_ready    <= 1'b1;
                    busy        <= 1'b0;
`ifdef UART_TX_BREAK_EN
                    if (start_break) begin
                        state       <= BREAK;
                        sh.bd       <= bd_sel;
                        brk_cnt     <= '0;
                        data_out_Tx <= 1'b0;
                        tx_ready    <= 1'b0;
                        busy        <= 1'b1;
                    end
`endif
                    if (start_frame) begin
                        state       <= START;
                        sh          <= '{data: data_in_Tx, bd: bd_sel, prty: prty_sel,
                                         stop: stop_sel, dbits: data_bit_sel};
                        bit_idx     <= '0;
                        stop_cnt    <= 1'b0;
                        data_out_Tx <= 1'b0;
                        tx_ready    <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state       <= DATA;
                        data_out_Tx <= sh.data[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == last_idx) begin
                            state       <= par_en ? PARITY : STOP;
                            data_out_Tx <= par_en ? par_bit : 1'b1;
                        end else begin
                            bit_idx     <= next_idx;
                            data_out_Tx <= sh.data[next_idx];
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        state       <= STOP;
                        data_out_Tx <= 1'b1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if ((sh.stop == STOP_2) && !stop_cnt) begin
                            stop_cnt <= 1'b1;
                        end else begin
                            state    <= IDLE;
                            tx_ready <= 1'b1;
                            busy     <= 1'b0;
                        end
                    end
                end
`ifdef UART_TX_BREAK_EN
                BREAK: begin
                    if (tick) begin
                        if (brk_cnt == BREAK_LAST) begin
                            state       <= IDLE;
                            data_out_Tx <= 1'b1;
                            tx_ready    <= 1'b1;
                            busy        <= 1'b0;
                        end else begin
                            brk_cnt <= brk_cnt + 4'd1;
                        end
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - directed self-checking bench for uart_tx_frame
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] bd_sel = 2'b00;
    logic [1:0] prty_sel = 2'b00;
    logic       stop_sel = 1'b0;
    logic       data_bit_sel = 1'b1;
    logic [7:0] data_in_Tx = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       data_out_Tx;
    logic       busy;
`ifdef UART_TX_BREAK_EN
    logic       brk_req = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // 96 kHz clock gives divisors 80/40/20/10 for 1200/2400/4800/9600.
    uart_tx_frame #(.CLK_HZ(96000)) dut (
        .clk          (clk),
        .rst          (rst),
        .bd_sel       (bd_sel),
        .prty_sel     (prty_sel),
        .stop_sel     (stop_sel),
        .data_bit_sel (data_bit_sel),
        .data_in_Tx   (data_in_Tx),
        .tx_valid     (tx_valid),
`ifdef UART_TX_BREAK_EN
        .brk_req      (brk_req),
`endif
        .tx_ready     (tx_ready),
        .data_out_Tx  (data_out_Tx),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic accept(input logic [7:0] d, input logic [1:0] bd, input logic [1:0] pr,
                          input logic st, input logic db, input bit hold);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!tx_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check("accept_ready", tx_ready, 1);
        data_in_Tx   = d;
        bd_sel       = bd;
        prty_sel     = pr;
        stop_sel     = st;
        data_bit_sel = db;
        tx_valid     = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) begin
            tx_valid     = 1'b0;
            data_in_Tx   = ~d;
            bd_sel       = ~bd;
            prty_sel     = (pr == 2'b01) ? 2'b10 : 2'b01;
            stop_sel     = ~st;
            data_bit_sel = ~db;
        end
    endtask

    // Called right after the accept edge; samples each bit at its first and last clock.
    task automatic check_frame(input string tag, input logic [15:0] exp, input int len, input int div);
        for (int n = 0; n <= len * div; n++) begin
            @(negedge clk);
            if (n < len * div) begin
                if ((n % div == 0) || (n % div == div - 1))
                    check({tag, ".line"}, data_out_Tx, exp[n / div]);
                if (n == 0) begin
                    check({tag, ".ready_lo"}, tx_ready, 0);
                    check({tag, ".busy_hi"}, busy, 1);
                end
                if (n == len * div - 1)
                    check({tag, ".ready_end"}, tx_ready, 0);
            end else begin
                check({tag, ".idle_line"}, data_out_Tx, 1);
                check({tag, ".ready_back"}, tx_ready, 1);
                check({tag, ".busy_lo"}, busy, 0);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst.line", data_out_Tx, 1);
        check("rst.ready", tx_ready, 0);
        check("rst.busy", busy, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rel.ready", tx_ready, 1);

        // 7N1 1200 0x0F: 0,1,1,1,1,0,0,0,1
        accept(8'h0F, 2'b00, 2'b00, 1'b0, 1'b0, 0);
        check_frame("f0F_7n1", 16'h011E, 9, 80);

        // 8E2 9600 0x2A: 0,01010100,1,1,1
        accept(8'h2A, 2'b11, 2'b10, 1'b1, 1'b1, 0);
        check_frame("f2A_8e2", 16'h0E54, 12, 10);

        // 8O1 4800 0xE1: parity 1; selectors scrambled mid-frame by accept()
        accept(8'hE1, 2'b10, 2'b01, 1'b0, 1'b1, 0);
        check_frame("fE1_8o1", 16'h07C2, 11, 20);

        // 7E1 9600 0x80: bit 7 excluded, parity 0
        accept(8'h80, 2'b11, 2'b10, 1'b0, 1'b0, 0);
        check_frame("f80_7e1", 16'h0200, 10, 10);

        // Reset mid-DATA at 2400
        accept(8'hFF, 2'b01, 2'b00, 1'b0, 1'b1, 0);
        repeat (100) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst.line", data_out_Tx, 1);
        check("midrst.busy", busy, 0);
        check("midrst.ready", tx_ready, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst.rel_ready0", tx_ready, 0);
        @(negedge clk);
        check("midrst.rel_ready1", tx_ready, 1);
        check("midrst.rel_busy", busy, 0);
        accept(8'h0F, 2'b01, 2'b00, 1'b0, 1'b0, 0);
        check_frame("after_rst", 16'h011E, 9, 40);

        // Back-to-back 0x55 then 0xAA at 9600 with tx_valid held
        accept(8'h55, 2'b11, 2'b00, 1'b0, 1'b1, 1);
        data_in_Tx = 8'hAA;
        check_frame("b2b_55", 16'h02AA, 10, 10);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        check_frame("b2b_AA", 16'h0354, 10, 10);

`ifdef UART_TX_BREAK_EN
        // Break has priority over a pending byte; 13 bit times at 4800
        @(negedge clk);
        check("brk.ready", tx_ready, 1);
        data_in_Tx   = 8'h55;
        bd_sel       = 2'b10;
        prty_sel     = 2'b00;
        stop_sel     = 1'b0;
        data_bit_sel = 1'b1;
        tx_valid     = 1'b1;
        brk_req      = 1'b1;
        @(posedge clk);
        #1;
        brk_req = 1'b0;
        for (int n = 0; n <= 13 * 20; n++) begin
            @(negedge clk);
            if (n < 13 * 20) begin
                if ((n == 0) || (n == 13 * 20 - 1)) begin
                    check("brk.line", data_out_Tx, 0);
                    check("brk.busy", busy, 1);
                    check("brk.ready", tx_ready, 0);
                end
            end else begin
                check("brk.end_line", data_out_Tx, 1);
                check("brk.end_ready", tx_ready, 1);
            end
        end
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        check_frame("brk_55", 16'h02AA, 10, 20);
`endif

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Serial frame transmitter, the transmit-side counterpart of the team's configurable UART receiver. It accepts one parallel byte per valid/ready handshake and shifts it out LSB-first on a single idle-high line: start bit, 7 or 8 data bits, optional odd/even parity, then 1 or 2 stop bits, at 1200/2400/4800/9600 baud. Its frame format and selector encodings match the receiver exactly, so the two blocks can be looped back directly.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency in Hz; sets the bit divisors.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `bd_sel`  in  2  baud select: 00=1200, 01=2400, 10=4800, 11=9600.
- `prty_sel`  in  2  parity select: 00=none, 01=odd, 10=even, 11=none.
- `stop_sel`  in  1  stop bits: 0=1, 1=2.
- `data_bit_sel`  in  1  data bits: 0=7 (bit 7 ignored), 1=8.
- `data_in_Tx`  in  8  parallel byte to send.
- `tx_valid`  in  1  byte on `data_in_Tx` is valid.
- `tx_ready`  out  1  block can accept a byte.
- `data_out_Tx`  out  1  serial line; idles high.
- `busy`  out  1  a frame or break is on the line.
- `brk_req`  in  1  break request. Present only when `UART_TX_BREAK_EN` is defined.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK (BREAK exists only with the macro).
- IDLE: `data_out_Tx`=1, `tx_ready`=1, `busy`=0.
- Accept: `tx_valid && tx_ready` at a clock edge.
  - Latch `data_in_Tx`, `bd_sel`, `prty_sel`, `stop_sel` and `data_bit_sel` into a shadow register.
  - Go to START.
  - Selector changes after the accept have no effect until the next accept.
- START: line 0 for one bit time.
- DATA: bits 0..N-1, LSB first. N is 7 or 8.
- PARITY: entered only if `prty_sel` is 01 or 10.
  - Even parity: bit = XOR of the N sent data bits.
  - Odd parity: bit = inverted XOR of the N sent data bits.
  - With N=7, bit 7 is excluded from the parity.
- STOP: line 1 for 1 or 2 bit times, then return to IDLE.
- Bit time is DIV clocks, with DIV = (CLK_HZ + baud/2) / baud. At 50 MHz: 41667, 20833, 10417, 5208.
  - The divisor counter is 16 bits.
  - The counter reloads at every bit boundary.
  - No cumulative drift: every bit is exactly DIV clocks.
- `tx_valid` while not ready: ignored. The data is not queued, and the source must hold it.
- Reset, including mid-frame: asynchronous.
  - State returns to IDLE; the frame is abandoned.
  - `data_out_Tx`=1, `tx_ready`=0 while reset is asserted, `busy`=0.
  - Shadow and counters are cleared.
  - `tx_ready`=1 on the first clock after reset is released.

## Timing
- Accept at edge k: the line falls at edge k+1.
- A frame lasts (1 + N + P + S) × DIV clocks, where P is 0 or 1 and S is 1 or 2.
- `tx_ready` stays 0 from edge k+1 until the clock after the last stop bit completes.
- Back-to-back frames: the idle gap is exactly 1 clock when `tx_valid` is held high.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Example frame length: 8 data bits, parity, 2 stop bits at 1200 baud = 12 × 41667 = 500004 clocks.

## Configuration
- `UART_TX_BREAK_EN` defined:
  - Adds the `brk_req` port.
  - In IDLE, `brk_req`=1 has priority over `tx_valid`.
  - Enters BREAK: line 0 for 13 bit times at the `bd_sel` value latched on entry, then IDLE.
  - During BREAK, `busy`=1 and `tx_ready`=0.
- `UART_TX_BREAK_EN` not defined: no port, no BREAK state, and no logic is inferred for it.

## Structure
- Package `uart_pkg`:
  - Baud selector, parity and stop encodings as localparams.
  - FSM state typedef.
  - Function `baud_div(CLK_HZ, bd_sel)` returning the 16-bit divisor.
- The receiver reuses the same package.
- Sub-module `baud_tick_gen`:
  - Inputs: `clk`, `rst`, `load`, `div[15:0]`.
  - Output: `tick`, pulsed one clock when the count reaches DIV-1.
  - `load` restarts the count at 0.

## Test plan
- Reset mid-DATA at 2400 baud -> line 1 immediately, `busy`=0; `tx_ready`=1 one clock after release; the next frame is correct.
- 7 bits, no parity, 1 stop, 1200 baud, byte 0x0F -> line sequence 0,1,1,1,1,0,0,0,1. Each bit is 41667 clocks; `tx_ready` returns 1 at clock 9×41667+1.
- 8 bits, even parity, 2 stop, byte 0x2A -> 0, 01010100, parity 1, 1, 1. Total 12 bit times.
- 8 bits, odd parity, byte 0xE1 -> parity bit 1. Change `prty_sel` to 10 mid-frame -> the current frame is unchanged.
- Back-to-back 0x55 then 0xAA at 9600 with `tx_valid` held high -> exactly 1 idle clock between the stop bit and the next start bit. Loopback into the receiver gives both bytes with no `err_prty` and no `err_frame`.
- With `UART_TX_BREAK_EN`, `brk_req` and `tx_valid` high together in IDLE at 4800 -> line 0 for 13×10417 clocks, then the pending byte is accepted.
